// File: rtl/muldiv_unit_pkg.sv
// rtl/muldiv_unit_pkg.sv - shared types for the iterative multiply/divide unit
// Purpose: operation encoding, FSM states, control decode and common shared types.
// Contents: muldiv_op_t, muldiv_state_t, control_bits, MemoryWord, MULDIV_ITER_MAX, decode_op().
package muldiv_unit_pkg;

    typedef enum logic [3:0] {
        OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
        OP_DIV, OP_DIVU, OP_REM, OP_REMU,
        OP_MULW, OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW
    } muldiv_op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_DONE
    } muldiv_state_t;

    // Worst case: XLEN=64 retired one bit per cycle.
    localparam int MULDIV_ITER_MAX = 64;

    typedef logic [63:0] MemoryWord;

    typedef struct packed {
        logic is_div;     // divide or remainder
        logic is_rem;     // return remainder instead of quotient
        logic is_word;    // 32-bit op with sign-extended result
        logic a_signed;   // src_a interpreted as two's complement
        logic b_signed;   // src_b interpreted as two's complement
        logic high_half;  // return upper half of the product
    } control_bits;

    function automatic control_bits decode_op(input muldiv_op_t op);
        control_bits c;
        c = '0;
        case (op)
            OP_MUL:    ;
            OP_MULH:   begin c.a_signed = 1'b1; c.b_signed = 1'b1; c.high_half = 1'b1; end
            OP_MULHSU: begin c.a_signed = 1'b1; c.high_half = 1'b1; end
            OP_MULHU:  c.high_half = 1'b1;
            OP_DIV:    begin c.is_div = 1'b1; c.a_signed = 1'b1; c.b_signed = 1'b1; end
            OP_DIVU:   c.is_div = 1'b1;
            OP_REM:    begin c.is_div = 1'b1; c.is_rem = 1'b1; c.a_signed = 1'b1; c.b_signed = 1'b1; end
            OP_REMU:   begin c.is_div = 1'b1; c.is_rem = 1'b1; end
            OP_MULW:   c.is_word = 1'b1;
            OP_DIVW:   begin c.is_div = 1'b1; c.is_word = 1'b1; c.a_signed = 1'b1; c.b_signed = 1'b1; end
            OP_DIVUW:  begin c.is_div = 1'b1; c.is_word = 1'b1; end
            OP_REMW:   begin c.is_div = 1'b1; c.is_rem = 1'b1; c.is_word = 1'b1;
                             c.a_signed = 1'b1; c.b_signed = 1'b1; end
            OP_REMUW:  begin c.is_div = 1'b1; c.is_rem = 1'b1; c.is_word = 1'b1; end
            default:   c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// rtl/muldiv_iter.sv - combinational UNROLL-bit shift-add / restoring shift-subtract step
// Purpose: advances the multiply or divide datapath by UNROLL bits, MSB first.
// Ports: is_div_i selects divide; acc_i/acc_o product or remainder (low XLEN bits);
//        sh_i/sh_o multiplier or dividend/quotient shift register; opnd_i multiplicand or divisor.
module muldiv_iter #(
    parameter int XLEN   = 64,
    parameter int UNROLL = 1
) (
    input  logic              is_div_i,
    input  logic [2*XLEN-1:0] acc_i,
    input  logic [XLEN-1:0]   sh_i,
    input  logic [XLEN-1:0]   opnd_i,
    output logic [2*XLEN-1:0] acc_o,
    output logic [XLEN-1:0]   sh_o
);

    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   sh;
    logic [XLEN:0]     rem;
    logic              qbit;

    always_comb begin
        acc  = acc_i;
        sh   = sh_i;
        rem  = '0;
        qbit = 1'b0;
        for (int i = 0; i < UNROLL; i++) begin
            if (is_div_i) begin
                // Bring the next dividend bit into the partial remainder.
                rem  = {acc[XLEN-1:0], sh[XLEN-1]};
                qbit = (rem >= {1'b0, opnd_i});
                if (qbit) begin
                    rem = rem - {1'b0, opnd_i};
                end
                acc = {{(XLEN-1){1'b0}}, rem};
                sh  = {sh[XLEN-2:0], qbit};
            end else begin
                // Multiplier is consumed MSB first, so the product doubles each step.
                acc = (acc << 1) + (sh[XLEN-1] ? {{XLEN{1'b0}}, opnd_i} : {(2*XLEN){1'b0}});
                sh  = sh << 1;
            end
        end
        acc_o = acc;
        sh_o  = sh;
    end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative integer multiply/divide unit with valid/ready handshake
// Purpose: FSM, iteration counter, operand sign handling, special divide cases, result fix-up.
// Ports: clk, reset_n (async active-low); in_valid/in_ready, op, src_a, src_b, tag_in accept side;
//        flush kills the operation; out_valid/out_ready, result, tag_out retire side.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int UNROLL = 1,
    parameter int TAG_W  = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  muldiv_op_t       op,
    input  logic [XLEN-1:0]  src_a,
    input  logic [XLEN-1:0]  src_b,
    input  logic [TAG_W-1:0] tag_in,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  result,
    output logic [TAG_W-1:0] tag_out
);

    localparam int              CNT_W    = $clog2(XLEN/UNROLL + 1);
    localparam logic [CNT_W-1:0] ITER_X  = CNT_W'(XLEN/UNROLL);
    localparam logic [CNT_W-1:0] ITER_WD = CNT_W'(32/UNROLL);
    localparam bit              HAS_WORD = (XLEN == 64);

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    function automatic logic [XLEN-1:0] zext32(input logic [31:0] v);
        return XLEN'(v);
    endfunction

    muldiv_state_t     state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d, acc_nx;
    logic [XLEN-1:0]   sh_q, sh_d, sh_nx;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic              is_div_q, is_div_d, is_rem_q, is_rem_d, high_q, high_d, word_q, word_d;
    logic              negq_q, negq_d, negr_q, negr_d, special_q, special_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic              out_valid_q, out_valid_d;

    // Accept-side operand preparation.
    control_bits       ctl_in;
    logic              word_in, a_neg, b_neg, b_zero, ovf;
    logic [XLEN-1:0]   a_val, b_val, a_mag, b_mag, a_ext, spec_res, sh_init;

    always_comb begin
        ctl_in  = decode_op(op);
        // With XLEN=32 the word ops collapse onto their full-width counterparts.
        word_in = ctl_in.is_word & HAS_WORD;
        a_val   = word_in ? (ctl_in.a_signed ? sext32(src_a[31:0]) : zext32(src_a[31:0])) : src_a;
        b_val   = word_in ? (ctl_in.b_signed ? sext32(src_b[31:0]) : zext32(src_b[31:0])) : src_b;
        a_neg   = ctl_in.a_signed & a_val[XLEN-1];
        b_neg   = ctl_in.b_signed & b_val[XLEN-1];
        a_mag   = a_neg ? -a_val : a_val;
        b_mag   = b_neg ? -b_val : b_val;
        // Special-case results are sign-extended from bit 31 even for the unsigned word ops.
        a_ext   = word_in ? sext32(src_a[31:0]) : src_a;
        b_zero  = (b_val == '0);
        ovf     = ctl_in.a_signed & (b_val == '1) &
                  (word_in ? (a_val == sext32(32'h8000_0000)) : (a_val == {1'b1, {(XLEN-1){1'b0}}}));
        if (b_zero) begin
            spec_res = ctl_in.is_rem ? a_ext : '1;
        end else begin
            spec_res = ctl_in.is_rem ? '0 : a_ext;
        end
        // Word operands sit in the top 32 bits so the MSB-first step sees them first.
        sh_init = ctl_in.is_div ? a_mag : b_mag;
        if (word_in) begin
            sh_init = sh_init << (XLEN - 32);
        end
    end

    muldiv_iter #(
        .XLEN   (XLEN),
        .UNROLL (UNROLL)
    ) u_iter (
        .is_div_i (is_div_q),
        .acc_i    (acc_q),
        .sh_i     (sh_q),
        .opnd_i   (opnd_q),
        .acc_o    (acc_nx),
        .sh_o     (sh_nx)
    );

    // Sign fix-up of the finished unsigned iteration.
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   fix;

    always_comb begin
        prod_s = negq_q ? -acc_q : acc_q;
        if (is_div_q) begin
            if (is_rem_q) begin
                fix = negr_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
            end else begin
                fix = negq_q ? -sh_q : sh_q;
            end
        end else begin
            fix = high_q ? prod_s[2*XLEN-1:XLEN] : prod_s[XLEN-1:0];
        end
        if (word_q) begin
            fix = sext32(fix[31:0]);
        end
    end

    logic [CNT_W-1:0] last_cnt;
    assign last_cnt = (word_q ? ITER_WD : ITER_X) - 1'b1;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        sh_d        = sh_q;
        opnd_d      = opnd_q;
        is_div_d    = is_div_q;
        is_rem_d    = is_rem_q;
        high_d      = high_q;
        word_d      = word_q;
        negq_d      = negq_q;
        negr_d      = negr_q;
        special_d   = special_q;
        result_d    = result_q;
        tag_d       = tag_q;
        out_valid_d = out_valid_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    is_div_d  = ctl_in.is_div;
                    is_rem_d  = ctl_in.is_rem;
                    high_d    = ctl_in.high_half;
                    word_d    = word_in;
                    negq_d    = a_neg ^ b_neg;
                    negr_d    = a_neg;
                    tag_d     = tag_in;
                    cnt_d     = '0;
                    if (ctl_in.is_div && (b_zero || ovf)) begin
                        special_d = 1'b1;
                        result_d  = spec_res;
                        state_d   = ST_DONE;
                    end else begin
                        special_d = 1'b0;
                        acc_d     = '0;
                        sh_d      = sh_init;
                        opnd_d    = ctl_in.is_div ? b_mag : a_mag;
                        state_d   = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                acc_d = acc_nx;
                sh_d  = sh_nx;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == last_cnt) begin
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // First DONE cycle registers the final value; out_valid follows it.
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                    if (!special_q) begin
                        result_d = fix;
                    end
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (flush) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
            cnt_d       = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            sh_q        <= '0;
            opnd_q      <= '0;
            is_div_q    <= 1'b0;
            is_rem_q    <= 1'b0;
            high_q      <= 1'b0;
            word_q      <= 1'b0;
            negq_q      <= 1'b0;
            negr_q      <= 1'b0;
            special_q   <= 1'b0;
            result_q    <= '0;
            tag_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            sh_q        <= sh_d;
            opnd_q      <= opnd_d;
            is_div_q    <= is_div_d;
            is_rem_q    <= is_rem_d;
            high_q      <= high_d;
            word_q      <= word_d;
            negq_q      <= negq_d;
            negr_q      <= negr_d;
            special_q   <= special_d;
            result_q    <= result_d;
            tag_q       <= tag_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign tag_out   = tag_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - scoreboard bench for muldiv_unit with directed vectors
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    muldiv_op_t  op_s = OP_MUL;
    logic [63:0] src_a = '0;
    logic [63:0] src_b = '0;
    logic [5:0]  tag_in = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] result;
    logic [5:0]  tag_out;

    muldiv_unit #(.XLEN(64), .UNROLL(1), .TAG_W(6)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op_s),
        .src_a     (src_a),
        .src_b     (src_b),
        .tag_in    (tag_in),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .tag_out   (tag_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] res;
        logic [5:0]  tag;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   total_cnt = 0;
    int   pass_cnt = 0;
    logic prev_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
        end
    endtask

    // Monitor: pops the expected response when out_valid rises, then checks it is held.
    always @(negedge clk) begin
        if (out_valid && !prev_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out_valid", 64'(out_valid), 64'd0);
            end else begin
                cur = exp_q.pop_front();
                check("latency", 64'(cyc - acc_cyc), 64'(cur.lat));
                check("result", result, cur.res);
                check("tag_out", 64'(tag_out), 64'(cur.tag));
            end
        end else if (out_valid && prev_valid) begin
            check("hold_result", result, cur.res);
            check("hold_tag", 64'(tag_out), 64'(cur.tag));
        end
        prev_valid = out_valid;
    end

    task automatic issue(input muldiv_op_t o, input logic [63:0] a, input logic [63:0] b,
                         input logic [5:0] t, input logic [63:0] e, input int lat, input bit push);
        int n;
        exp_t x;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("issue_ready", 64'(in_ready), 64'd1);
        op_s = o; src_a = a; src_b = b; tag_in = t; in_valid = 1'b1;
        if (push) begin
            x.res = e; x.tag = t; x.lat = lat;
            exp_q.push_back(x);
        end
        @(negedge clk);
        acc_cyc  = cyc;
        in_valid = 1'b0;
        // Later input changes must not disturb the captured operation.
        op_s = OP_MULHU; src_a = ~a; src_b = ~b; tag_in = ~t;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !in_ready) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("wait_done", 64'(exp_q.size() == 0 && in_ready), 64'd1);
    endtask

    task automatic run(input muldiv_op_t o, input logic [63:0] a, input logic [63:0] b,
                       input logic [5:0] t, input logic [63:0] e, input int lat);
        issue(o, a, b, t, e, lat, 1'b1);
        wait_done();
    endtask

    task automatic watch_quiet(input int cycles);
        int seen;
        seen = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("no_output", 64'(seen), 64'd0);
    endtask

    initial begin
        int n;
        #2;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_result", result, 64'd0);
        check("rst_tag_out", 64'(tag_out), 64'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);

        // Special cases: latency 1.
        run(OP_DIV,   64'd7, 64'd0, 6'h01, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        run(OP_REM,   64'd7, 64'd0, 6'h02, 64'd7, 1);
        run(OP_DIV,   64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 6'h03, 64'h8000_0000_0000_0000, 1);
        run(OP_REM,   64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 6'h04, 64'd0, 1);
        run(OP_DIVW,  64'd9, 64'h0000_0001_0000_0000, 6'h05, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        run(OP_REMUW, 64'h0000_0000_8000_0005, 64'd0, 6'h06, 64'hFFFF_FFFF_8000_0005, 1);
        run(OP_DIVW,  64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 6'h07, 64'hFFFF_FFFF_8000_0000, 1);

        // Full-width iterations: latency 65.
        run(OP_MULHU, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 6'h08, 64'hFFFF_FFFF_FFFF_FFFE, 65);
        run(OP_MULH,  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 6'h09, 64'd0, 65);
        run(OP_MULHSU,64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 6'h0A, 64'hFFFF_FFFF_FFFF_FFFF, 65);
        run(OP_MUL,   64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 6'h0B, 64'hFFFF_FFFF_FFFF_FFF1, 65);
        run(OP_DIV,   64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 6'h0C, 64'hFFFF_FFFF_FFFF_FFFA, 65);
        run(OP_REM,   64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 6'h0D, 64'hFFFF_FFFF_FFFF_FFFE, 65);
        run(OP_DIVU,  64'd100, 64'd7, 6'h0E, 64'd14, 65);
        run(OP_REMU,  64'd100, 64'd7, 6'h0F, 64'd2, 65);

        // Word iterations: latency 33.
        run(OP_DIVUW, 64'h0000_0000_FFFF_FFFF, 64'd1, 6'h10, 64'hFFFF_FFFF_FFFF_FFFF, 33);
        run(OP_REMW,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 6'h11, 64'hFFFF_FFFF_FFFF_FFFF, 33);
        run(OP_MULW,  64'h0000_0000_7FFF_FFFF, 64'd2, 6'h12, 64'hFFFF_FFFF_FFFF_FFFE, 33);

        // Back-pressure: hold out_ready low for 5 cycles in DONE.
        out_ready = 1'b0;
        issue(OP_DIVU, 64'd100, 64'd7, 6'h2A, 64'd14, 65, 1'b1);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("hold_seen_valid", 64'(out_valid), 64'd1);
        repeat (5) begin
            @(negedge clk);
            check("hold_in_ready", 64'(in_ready), 64'd0);
            check("hold_out_valid", 64'(out_valid), 64'd1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("retire_in_ready", 64'(in_ready), 64'd1);
        check("retire_out_valid", 64'(out_valid), 64'd0);

        // Flush at CALC cycle 10.
        issue(OP_MULHU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 6'h15, 64'd0, 0, 1'b0);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_in_ready", 64'(in_ready), 64'd1);
        check("flush_out_valid", 64'(out_valid), 64'd0);
        watch_quiet(80);

        // Reset pulse mid-CALC.
        issue(OP_DIVU, 64'd1000, 64'd3, 6'h16, 64'd0, 0, 1'b0);
        repeat (5) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_result", result, 64'd0);
        check("midrst_tag", 64'(tag_out), 64'd0);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        watch_quiet(80);

        run(OP_MUL, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 6'h17, 64'hFFFF_FFFF_FFFF_FFF1, 65);

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
